// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: T1-T4 bus-cycle controller with READY wait states and timeout
module bus_cycle_sequencer #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  OP,
   input  logic [19:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic [19:0] Direction,
   output logic [7:0]  Data,
   output logic        data_oe,
   input  logic [7:0]  bus_rdata,
   output logic        ALE,
   output logic        RD_n,
   output logic        WR_n,
   output logic        IO_M,
   input  logic        READY
);
   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;
   state_t      r_state, w_next;
   logic        r_rd;
   logic [3:0]  r_wait;
   logic        w_accept, w_legal, w_strobe, w_done, w_timeout;
   // state register; reset drops any in-flight cycle immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end
   // next-state and Moore output decode; strobes depend only on state and latched op
   always_comb begin
      w_next    = r_state;
      req_ready = (r_state == S_IDLE) && !reset;
      w_accept  = req_valid && req_ready;
      w_legal   = OP inside {3'd1, 3'd2, 3'd3, 3'd4};
      w_strobe  = r_state inside {S_T2, S_T3, S_TW};
      w_done    = (r_state inside {S_T3, S_TW}) && READY;
      w_timeout = (r_state == S_TW) && !READY && (r_wait == 4'(WAIT_MAX - 1));
      ALE       = r_state == S_T1;
      RD_n      = !(w_strobe && r_rd);
      WR_n      = !(w_strobe && !r_rd);
      data_oe   = w_strobe && !r_rd;
      rsp_valid = r_state == S_T4;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_legal ? S_T1 : S_T4;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = S_T3;
         S_T3:    w_next = READY ? S_T4 : S_TW;
         S_TW:    w_next = (READY || w_timeout) ? S_T4 : S_TW;
         default: w_next = S_IDLE;
      endcase
   end
   // command latch, wait counter and response registers (updated on the edge entering T4)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd      <= 1'b0;
         r_wait    <= 4'd0;
         IO_M      <= 1'b0;
         Direction <= '0;
         Data      <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            Data <= req_wdata;
            IO_M <= (OP == 3'd3) || (OP == 3'd4);
            r_rd <= (OP == 3'd1) || (OP == 3'd3);
            if (w_legal) Direction <= req_addr;
            else begin
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end
         r_wait <= (r_state == S_TW) ? r_wait + 4'd1 : 4'd0;
         if (w_done) begin
            rsp_data <= r_rd ? bus_rdata : 8'd0;
            rsp_err  <= 1'b0;
         end else if (w_timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb_bus_cycle_sequencer: randomized scoreboard bench with a cycle-offset reference model
module tb_bus_cycle_sequencer;
   localparam int WM = 3;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid, req_ready, rsp_valid, rsp_err, data_oe, ALE, RD_n, WR_n, IO_M, READY;
   logic [2:0]  OP;
   logic [19:0] req_addr, Direction;
   logic [7:0]  req_wdata, rsp_data, Data, bus_rdata;
   typedef struct {
      int          acc;
      int          fin;
      logic        legal, rd, io, err;
      logic [19:0] addr;
      logic [7:0]  wdata, data;
   } txn_t;
   txn_t        q[$];
   txn_t        h;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          off;
   bit          busy, strobe, fin_now;
   logic [19:0] exp_dir = '0;
   logic [7:0]  last_data = '0;
   logic        last_err = 1'b0;

   bus_cycle_sequencer #(.WAIT_MAX(WM)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .OP(OP),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .Direction(Direction), .Data(Data), .data_oe(data_oe),
      .bus_rdata(bus_rdata), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IO_M(IO_M), .READY(READY)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Issue one command and play the bus side: READY goes high 'w' cycles after T3 unless tmo.
   // rst_at > 0 asserts reset at that cycle offset and abandons the command.
   task automatic send(input logic [2:0] op, input logic [19:0] addr, input logic [7:0] wd,
                       input int w, input bit tmo, input int rst_at, input logic [7:0] rdv);
      txn_t t;
      tick();
      req_valid = 1'b1;
      OP        = op;
      req_addr  = addr;
      req_wdata = wd;
      READY     = 1'($urandom);
      bus_rdata = 8'($urandom);
      chk("issue_ready", 32'(req_ready), 32'(1));
      t.acc   = cyc;
      t.legal = (op >= 3'd1) && (op <= 3'd4);
      t.rd    = (op == 3'd1) || (op == 3'd3);
      t.io    = (op == 3'd3) || (op == 3'd4);
      t.fin   = !t.legal ? 1 : 4 + (tmo ? WM : w);
      t.err   = !t.legal || tmo;
      t.data  = (t.legal && t.rd && !tmo) ? rdv : 8'd0;
      t.addr  = addr;
      t.wdata = wd;
      q.push_back(t);
      for (int o = 1; o <= t.fin; o++) begin
         tick();
         req_valid = 1'($urandom);
         OP        = 3'($urandom);
         req_addr  = 20'($urandom);
         req_wdata = 8'($urandom);
         READY     = (o >= 3 && o < t.fin) ? (!tmo && o == 3 + w) : 1'($urandom);
         bus_rdata = (o == 3 + w) ? rdv : 8'($urandom);
         if (o == rst_at) begin
            reset     = 1'b1;
            req_valid = 1'b0;
            #1;
            chk("rst_RD_n", 32'(RD_n), 32'(1));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_ALE", 32'(ALE), 32'(0));
            repeat (2) tick();
            reset = 1'b0;
            return;
         end
      end
   endtask

   // monitor: derives expected bus activity from the cycle offset of the head transaction
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         exp_dir   = '0;
         last_data = '0;
         last_err  = 1'b0;
      end
      busy = 1'b0;
      if (q.size() > 0) begin
         h    = q[0];
         busy = cyc > h.acc;
      end
      off     = busy ? cyc - h.acc : 0;
      strobe  = busy && h.legal && off >= 2 && off < h.fin;
      fin_now = busy && (rsp_valid || off == h.fin);
      chk("ALE", 32'(ALE), 32'(busy && h.legal && off == 1));
      chk("RD_n", 32'(RD_n), 32'(!(strobe && h.rd)));
      chk("WR_n", 32'(WR_n), 32'(!(strobe && !h.rd)));
      chk("data_oe", 32'(data_oe), 32'(strobe && !h.rd));
      chk("req_ready", 32'(req_ready), 32'(!busy && !reset));
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && off == h.fin));
      chk("Direction", 32'(Direction), 32'((busy && h.legal) ? h.addr : exp_dir));
      if (busy) chk("IO_M", 32'(IO_M), 32'(h.io));
      if (strobe && !h.rd) chk("Data", 32'(Data), 32'(h.wdata));
      if (fin_now) begin
         chk("rsp_data", 32'(rsp_data), 32'(h.data));
         chk("rsp_err", 32'(rsp_err), 32'(h.err));
         last_data = h.data;
         last_err  = h.err;
         if (h.legal) exp_dir = h.addr;
         void'(q.pop_front());
      end else begin
         chk("rsp_data_hold", 32'(rsp_data), 32'(last_data));
         chk("rsp_err_hold", 32'(rsp_err), 32'(last_err));
      end
   end

   initial begin
      req_valid = 1'b0;
      OP        = '0;
      req_addr  = '0;
      req_wdata = '0;
      bus_rdata = '0;
      READY     = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      send(3'd1, 20'hABCDE, 8'h00, 0, 1'b0, 0, 8'h5A);
      send(3'd4, 20'h003F8, 8'hC3, 2, 1'b0, 0, 8'h00);
      send(3'd1, 20'h11111, 8'h00, 0, 1'b1, 0, 8'h77);
      send(3'd7, 20'h12345, 8'h99, 0, 1'b0, 0, 8'h00);
      send(3'd1, 20'h00001, 8'h00, 0, 1'b0, 0, 8'h21);
      send(3'd1, 20'h00002, 8'h00, 0, 1'b0, 0, 8'h42);
      send(3'd3, 20'h00060, 8'h00, WM, 1'b0, 0, 8'hE7);
      send(3'd2, 20'h80000, 8'h3C, 1, 1'b0, 0, 8'h00);
      send(3'd1, 20'hFFFFF, 8'h00, 0, 1'b1, 5, 8'h00);
      send(3'd0, 20'h54321, 8'h00, 0, 1'b0, 0, 8'h00);
      for (int i = 0; i < 120; i++) begin
         repeat ($urandom_range(0, 2)) begin
            tick();
            req_valid = 1'b0;
            READY     = 1'($urandom);
         end
         send(3'($urandom), 20'($urandom), 8'($urandom), $urandom_range(0, WM),
              $urandom_range(0, 4) == 0, 0, 8'($urandom));
      end
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      chk("drain", 32'(q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle %0d: bench did not finish", cyc);
      $fatal(1);
   end
endmodule
